// File: rtl/avalon_lsu_if.sv
// Shared 32-bit data type and the Avalon-MM read/write bus used by the data-side LSU.
package Types;
  typedef logic [31:0] tri32_t;
endpackage

interface AvalonMmRw;
  Types::tri32_t address;
  logic [3:0]    byteenable;
  logic          read;
  logic          write;
  Types::tri32_t host_to_agent;
  Types::tri32_t agent_to_host;
  logic          waitrequest;
  logic          readdatavalid;

  modport Host (
    output address, byteenable, read, write, host_to_agent,
    input  agent_to_host, waitrequest, readdatavalid
  );

  modport Agent (
    input  address, byteenable, read, write, host_to_agent,
    output agent_to_host, waitrequest, readdatavalid
  );
endinterface

// File: rtl/avalon_lsu.sv
// RV32 load/store unit: one byte/half/word access at a time onto an Avalon-MM host port.
module avalon_lsu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  AvalonMmRw.Host     bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DONE} state_t;

  state_t     state;
  logic       we_l;
  logic [2:0] f3_l;
  logic [1:0] lo_l;

  logic        bad;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  always_comb begin
    bad = 1'b0;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) bad = 1'b1;
    if (we && funct3[2]) bad = 1'b1;
    if (funct3[1:0] == 2'b01 && addr[0]) bad = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;

    // Mask to the access size first so unselected lanes go out as zero.
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {24'h0, wdata[7:0]} << {addr[1:0], 3'b000};
      end
      2'b01: begin
        be_c    = 4'b0011 << addr[1:0];
        wdata_c = {16'h0, wdata[15:0]} << {addr[1:0], 3'b000};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
    endcase

    rd_shift = bus.agent_to_host >> {lo_l, 3'b000};
    case (f3_l[1:0])
      2'b00:   rd_ext = {{24{rd_shift[7] & ~f3_l[2]}}, rd_shift[7:0]};
      2'b01:   rd_ext = {{16{rd_shift[15] & ~f3_l[2]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  assign busy = (state == REQ) || (state == WAIT_DATA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      we_l              <= 1'b0;
      f3_l              <= '0;
      lo_l              <= '0;
      done              <= 1'b0;
      err               <= 1'b0;
      rdata             <= '0;
      bus.address       <= '0;
      bus.byteenable    <= '0;
      bus.host_to_agent <= '0;
      bus.read          <= 1'b0;
      bus.write         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_l <= we;
            f3_l <= funct3;
            lo_l <= addr[1:0];
            if (bad) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state             <= REQ;
              bus.address       <= {addr[31:2], 2'b00};
              bus.byteenable    <= be_c;
              bus.host_to_agent <= wdata_c;
              bus.read          <= ~we;
              bus.write         <= we;
            end
          end
        end
        REQ: begin
          if (!bus.waitrequest) begin
            bus.read  <= 1'b0;
            bus.write <= 1'b0;
            if (we_l) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (bus.readdatavalid) begin
            rdata <= rd_ext;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
